// File: rtl/wiring_sched_pkg.sv
// Shared definitions for the wiring scheduler: FSM state encoding,
// default parameter values and the requester-id width helper.
package wiring_sched_pkg;

  typedef enum logic [2:0] {
    ST_INIT    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_DRIVE   = 3'd2,
    ST_SETTLE  = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_CLEAR   = 3'd5,
    ST_RESPOND = 3'd6
  } state_t;

  localparam int DEF_INPUT_WIDTH   = 3;
  localparam int DEF_OUTPUT_WIDTH  = 2;
  localparam int DEF_NUM_REQ       = 2;
  localparam int DEF_STABLE_CYCLES = 2;
  localparam int DEF_SETTLE_MAX    = 255;

  // A single requester still needs a 1-bit id field.
  function automatic int id_width(input int n);
    if (n > 1) begin
      return $clog2(n);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/wiring_scheduler_rr_arbiter.sv
// Round-robin arbiter: grants the first asserted request at or after ptr,
// wrapping modulo NUM_REQ. Purely combinational, one-hot or zero grant.
module rr_arbiter
  import wiring_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PW      = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PW-1:0]      ptr,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant
);

  logic [PW-1:0] w_idx;
  logic          w_hit;
  logic          w_found;

  // Walk requesters starting at ptr; the first hit wins and blocks the rest.
  always_comb begin
    grant   = '0;
    w_idx   = '0;
    w_hit   = 1'b0;
    w_found = 1'b0;
    for (int off = 0; off < NUM_REQ; off++) begin
      w_idx        = PW'((int'(ptr) + off) % NUM_REQ);
      w_hit        = enable & ~w_found & req[w_idx];
      grant[w_idx] = grant[w_idx] | w_hit;
      w_found      = w_found | w_hit;
    end
  end

endmodule

// File: rtl/wiring_scheduler.sv
// Serialises requests onto a shared Wiring block: drive inputs, wait for the
// logic to settle (or time out), capture outputs, clear, and respond.
module wiring_scheduler
  import wiring_sched_pkg::*;
#(
  parameter int INPUT_WIDTH   = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH  = DEF_OUTPUT_WIDTH,
  parameter int NUM_REQ       = DEF_NUM_REQ,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SETTLE_MAX    = DEF_SETTLE_MAX
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0]   req_in,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             rsp_valid,
  input  logic                             rsp_ready,
  output logic [id_width(NUM_REQ)-1:0]     rsp_id,
  output logic [OUTPUT_WIDTH-1:0]          rsp_out,
  output logic                             rsp_timeout,
  output logic [INPUT_WIDTH-1:0]           wiring_in,
  output logic                             wiring_logic_reset,
  input  logic                             wiring_running,
  input  logic [OUTPUT_WIDTH-1:0]          wiring_out,
  output logic                             busy
);

  localparam int IDW = id_width(NUM_REQ);
  localparam int CW  = $clog2(SETTLE_MAX + 1);

  state_t                  r_state;
  logic [INPUT_WIDTH-1:0]  r_vec;
  logic [IDW-1:0]          r_id;
  logic [IDW-1:0]          r_ptr;
  logic [CW-1:0]           r_quiet;
  logic [CW-1:0]           r_tmo;
  logic [OUTPUT_WIDTH-1:0] r_rsp_out;
  logic                    r_timeout;

  logic [NUM_REQ-1:0]      w_grant;
  logic [IDW-1:0]          w_gnt_id;
  logic [IDW-1:0]          w_next_ptr;
  logic [INPUT_WIDTH-1:0]  w_gnt_vec;
  logic [CW-1:0]           w_quiet_next;
  logic [CW-1:0]           w_tmo_next;
  logic                    w_quiet_done;
  logic                    w_tmo_done;
  logic                    w_idle;

  assign w_idle = (r_state == ST_IDLE);

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PW      (IDW)
  ) u_arb (
    .req    (req_valid),
    .ptr    (r_ptr),
    .enable (w_idle),
    .grant  (w_grant)
  );

  // Encode the one-hot grant into an id and select that requester's vector.
  always_comb begin
    w_gnt_id  = '0;
    w_gnt_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_gnt_id  = w_gnt_id | (w_grant[i] ? IDW'(i) : IDW'(0));
      w_gnt_vec = w_gnt_vec |
                  (req_in[i*INPUT_WIDTH +: INPUT_WIDTH] & {INPUT_WIDTH{w_grant[i]}});
    end
    if (w_gnt_id == IDW'(NUM_REQ - 1)) begin
      w_next_ptr = '0;
    end else begin
      w_next_ptr = w_gnt_id + IDW'(1);
    end
  end

  // Next values of the settle counters, including the current cycle; both saturate.
  always_comb begin
    if (wiring_running) begin
      w_quiet_next = '0;
    end else if (r_quiet == '1) begin
      w_quiet_next = r_quiet;
    end else begin
      w_quiet_next = r_quiet + CW'(1);
    end
    if (r_tmo == '1) begin
      w_tmo_next = r_tmo;
    end else begin
      w_tmo_next = r_tmo + CW'(1);
    end
    w_quiet_done = (w_quiet_next >= CW'(STABLE_CYCLES));
    w_tmo_done   = (w_tmo_next >= CW'(SETTLE_MAX));
  end

  // Transaction sequencer; quiet exit takes priority when both limits hit together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_INIT;
      r_vec     <= '0;
      r_id      <= '0;
      r_ptr     <= '0;
      r_quiet   <= '0;
      r_tmo     <= '0;
      r_rsp_out <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (|w_grant) begin
            r_vec   <= w_gnt_vec;
            r_id    <= w_gnt_id;
            r_ptr   <= w_next_ptr;
            r_state <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          r_quiet <= '0;
          r_tmo   <= '0;
          r_state <= ST_SETTLE;
        end
        ST_SETTLE: begin
          r_quiet <= w_quiet_next;
          r_tmo   <= w_tmo_next;
          if (w_quiet_done) begin
            r_timeout <= 1'b0;
            r_state   <= ST_CAPTURE;
          end else if (w_tmo_done) begin
            r_timeout <= 1'b1;
            r_state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          r_rsp_out <= wiring_out;
          r_state   <= ST_CLEAR;
        end
        ST_CLEAR: begin
          r_state <= ST_RESPOND;
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_INIT;
        end
      endcase
    end
  end

  assign req_ready          = w_grant;
  assign rsp_valid          = (r_state == ST_RESPOND);
  assign rsp_id             = r_id;
  assign rsp_out            = r_rsp_out;
  assign rsp_timeout        = r_timeout;
  assign wiring_in          = (r_state == ST_DRIVE) ? r_vec : '0;
  assign wiring_logic_reset = (r_state == ST_INIT) || (r_state == ST_CLEAR);
  assign busy               = !w_idle;

endmodule

// File: doc/wiring_scheduler.md
WIRING_SCHEDULER -- requirements
Module: wiring_scheduler

Interface
REQ-001 Parameters SHALL be: INPUT_WIDTH, default 3, Wiring input width; OUTPUT_WIDTH, default 2, Wiring output width; NUM_REQ, default 2, number of requesters; STABLE_CYCLES, default 2, consecutive quiet cycles meaning settled; SETTLE_MAX, default 255, settle timeout in cycles.
REQ-002 Ports SHALL be: clk  in  1  sole clock, rising edge; reset  in  1  synchronous, active-high.
REQ-003 Request ports SHALL be: req_valid  in  NUM_REQ  per-requester request; req_in  in  NUM_REQ*INPUT_WIDTH  trigger vector, requester k at bits [k*INPUT_WIDTH +: INPUT_WIDTH]; req_ready  out  NUM_REQ  one-hot accept.
REQ-004 Response ports SHALL be: rsp_valid  out  1; rsp_ready  in  1; rsp_id  out  max(1,clog2(NUM_REQ))  granted requester; rsp_out  out  OUTPUT_WIDTH  captured Wiring outputs; rsp_timeout  out  1  settle timed out.
REQ-005 Wiring-side ports SHALL be: wiring_in  out  INPUT_WIDTH; wiring_logic_reset  out  1; wiring_running  in  1; wiring_out  in  OUTPUT_WIDTH; busy  out  1, high in every state except IDLE.

Function
REQ-006 The FSM SHALL have states INIT, IDLE, DRIVE, SETTLE, CAPTURE, CLEAR, RESPOND.
REQ-007 INIT SHALL last one cycle, assert wiring_logic_reset, then go to IDLE.
REQ-008 In IDLE, if any req_valid is high, the block SHALL grant round-robin: the first valid index at or after rr_ptr, modulo NUM_REQ.
REQ-009 On grant, req_ready SHALL be high for the granted index only, in that same IDLE cycle.
REQ-010 On grant, the block SHALL latch the vector and id, set rr_ptr to (granted+1) mod NUM_REQ, and go to DRIVE.
REQ-011 req_ready SHALL be all-zero in every state other than IDLE.
REQ-012 DRIVE SHALL last exactly one cycle, with wiring_in equal to the latched vector; wiring_in SHALL be zero in all other states.
REQ-013 SETTLE SHALL count consecutive cycles with wiring_running=0 (quiet count) and total SETTLE cycles (timeout count).
REQ-014 In SETTLE, the quiet count SHALL clear whenever wiring_running=1.
REQ-015 SETTLE SHALL exit to CAPTURE when the quiet count reaches STABLE_CYCLES, with rsp_timeout flag = 0.
REQ-016 SETTLE SHALL exit to CAPTURE when the timeout count reaches SETTLE_MAX with the quiet count not reached, with rsp_timeout flag = 1.
REQ-017 If the quiet and timeout limits are reached in the same cycle, the exit SHALL be the quiet exit (flag = 0).
REQ-018 CAPTURE SHALL last one cycle and register wiring_out into rsp_out.
REQ-019 CLEAR SHALL last one cycle with wiring_logic_reset=1, then go to RESPOND.
REQ-020 wiring_logic_reset SHALL be low in all states other than INIT and CLEAR.
REQ-021 RESPOND SHALL hold rsp_valid=1 with rsp_id, rsp_out and rsp_timeout stable until rsp_ready=1, then go to IDLE.
REQ-022 No request SHALL be granted in the cycle RESPOND completes; the earliest next grant is the following IDLE cycle.
REQ-023 An all-zero request vector SHALL be processed like any other request; it settles after STABLE_CYCLES quiet cycles.
REQ-024 Minimum latency SHALL be: grant in cycle G, DRIVE G+1, SETTLE G+2..G+1+STABLE_CYCLES, CAPTURE, CLEAR, rsp_valid from G+4+STABLE_CYCLES (G+6 at defaults).
REQ-025 Both counters SHALL be wide enough for SETTLE_MAX and SHALL saturate, never wrap.

Reset
REQ-026 While reset=1, at the clk edge the block SHALL set state INIT, rr_ptr 0, counters 0, and latched vector, rsp_id, rsp_out and rsp_timeout to 0.
REQ-027 Outputs SHALL be combinational decodes of state plus registered data, so that in the first cycle after reset req_ready=0, rsp_valid=0, wiring_in=0, busy=1 and wiring_logic_reset=1 (INIT).
REQ-028 Reset asserted mid-operation, in any state, SHALL abandon the transaction, discard any pending response, and re-enter INIT.

Structure
REQ-029 A shared wiring_sched_pkg SHALL hold the state enum and default parameter constants.
REQ-030 The round-robin arbiter SHALL be a sub-module rr_arbiter, parameterised by NUM_REQ, with inputs req, ptr and enable and one-hot output grant.
REQ-031 Target implementation size: 120-400 lines of RTL.

Verification
REQ-032 Reset release with no requests: wiring_logic_reset high for exactly 1 cycle, then busy=0 and all outputs 0.
REQ-033 Requester 0 sends req_in=3'b011; Wiring model running for 3 cycles after DRIVE, out=2'b01: rsp_id=0, rsp_out=2'b01, rsp_timeout=0, rsp_valid exactly once.
REQ-034 Both requesters hold req_valid=1 continuously: grants alternate 0,1,0,1; req_ready one-hot and high one cycle per grant.
REQ-035 wiring_running stuck at 1, SETTLE_MAX=8: CAPTURE after 8 SETTLE cycles, rsp_timeout=1, CLEAR still pulsed.
REQ-036 rsp_ready held low 5 cycles in RESPOND: rsp_* stable and no new grant while a new req_valid is pending; the grant follows after rsp_ready=1.
REQ-037 reset asserted during SETTLE: next cycle in INIT with no response ever issued, then normal service of the next request.
